trap_seq_ctrl: RTL and testbench
================================

Name: trap_seq_ctrl

Overview:
- Trap sequencer placed between the pipeline's exception/MRET sources and the machine-mode CSR file.
- Arbitrates simultaneous exception requests by priority and drives the CSR file's single-cycle exception-commit and MRET pulses.
- Drains the pipeline for a fixed number of cycles, then hands a redirect PC (trap vector or mepc) to the fetch stage over a valid/ready handshake.

Parameters:
- FLUSH_CYCLES, 3, number of cycles flush is held after the commit cycle; legal range 1..15.
- RESET_PC, 32'h0001_0000, reset value of redirect_pc; matches the pc register reset.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_misalign  in  1  instruction-address-misaligned request.
- req_illegal  in  1  illegal-instruction request.
- req_ecall  in  1  ECALL request.
- req_pc  in  32  PC of the requesting instruction.
- req_tval  in  32  trap value for the request.
- mret_req  in  1  MRET request.
- mret_target  in  32  current mepc value from the CSR file.
- trap_vector  in  32  trap vector address from the CSR file.
- redirect_ready  in  1  fetch stage accepts the redirect.
- e_raised  out  1  one-cycle exception commit pulse to the CSR file.
- e_cause  out  2  exception cause: `I_ADDR_MISALIGNMENT, `ILLEGAL_IR or `ECALL.
- e_pc  out  32  latched req_pc.
- e_tval  out  32  latched req_tval.
- is_mret  out  1  one-cycle MRET pulse to the CSR file.
- flush  out  1  kill all in-flight pipeline stages.
- redirect_valid  out  1  redirect_pc is valid.
- redirect_pc  out  32  target PC for fetch.
- busy  out  1  high whenever state is not IDLE; stalls the pipeline front end.

Behaviour:
- All outputs are registered.
- Reset (async, any state, including mid-sequence):
  - state goes to IDLE; flush counter cleared.
  - e_raised, is_mret, flush, redirect_valid and busy go to 0.
  - e_cause = 0, e_pc = 0, e_tval = 0, redirect_pc = RESET_PC.
- Requests are sampled only in IDLE. In every other state they are ignored; they are not queued.
- Arbitration in IDLE: misalign > illegal > ecall > mret.
  - Any exception request in the same cycle as mret_req: the exception wins and the MRET is dropped.
- States:
  - IDLE: busy=0.
    - Exception request: latch cause, req_pc and req_tval; go to RAISE.
    - Else mret_req: go to MRET.
    - Else stay in IDLE.
  - RAISE, exactly 1 cycle:
    - e_raised=1, flush=1, busy=1.
    - e_cause/e_pc/e_tval hold the latched values.
    - redirect_pc <= trap_vector sampled this cycle.
    - Next state: FLUSH; counter loaded with FLUSH_CYCLES.
  - MRET, exactly 1 cycle:
    - is_mret=1, flush=1, busy=1.
    - redirect_pc <= mret_target sampled this cycle, i.e. the mepc value before any CSR write lands.
    - Next state: FLUSH; counter loaded with FLUSH_CYCLES.
  - FLUSH:
    - flush=1; counter decrements each cycle.
    - Leaves when the counter equals 1, so it lasts exactly FLUSH_CYCLES cycles.
    - Next state: REDIRECT.
  - REDIRECT:
    - redirect_valid=1, flush=0; redirect_pc held stable.
    - Stays until redirect_valid && redirect_ready; that cycle is the transfer.
    - Next state: IDLE; redirect_valid=0 and busy=0 the following cycle.
- Latency, with a request in IDLE at cycle N:
  - e_raised or is_mret high at N+1.
  - flush high from N+1 through N+1+FLUSH_CYCLES.
  - redirect_valid first high at N+2+FLUSH_CYCLES.
- redirect_ready high before redirect_valid rises has no effect.
- A new request can be accepted in the cycle after busy falls.
- e_cause/e_pc/e_tval hold their values until the next accepted exception. e_raised is the only qualifier.
- Exactly one of e_raised or is_mret pulses per sequence, never both.

Test Plan:
- Reset mid-FLUSH (rst pulsed at N+2 of a sequence) -> immediately flush=0, busy=0, redirect_pc=32'h0001_0000; no redirect_valid afterwards.
- Single ECALL: req_pc=32'h0001_0040, trap_vector=32'h0000_0100, ready tied high -> e_raised at N+1 with e_cause=`ECALL and e_pc=32'h0001_0040; flush for N+1..N+4; redirect_valid at N+5 with redirect_pc=32'h0000_0100; busy=0 at N+6.
- req_misalign, req_illegal and mret_req in the same cycle, req_tval=32'h0001_0042 -> e_cause=`I_ADDR_MISALIGNMENT, e_tval=32'h0001_0042, is_mret never asserted.
- MRET with mret_target=32'h0001_0080 -> is_mret single pulse, e_raised=0 throughout, redirect_pc=32'h0001_0080.
- redirect_ready held low 5 cycles after redirect_valid -> redirect_valid and redirect_pc stable for those 5 cycles, busy=1; req_illegal pulsed during the wait is ignored (no second e_raised).
- FLUSH_CYCLES=1 build -> flush high exactly 2 cycles (RAISE plus 1); back-to-back ECALL issued the cycle after busy falls is accepted.

Source files
------------

// File: rtl/trap_seq_ctrl.sv
// Trap sequencer: arbitrates exception/MRET requests, pulses the CSR commit strobes,
// drains the pipeline for FLUSH_CYCLES cycles and hands a redirect PC to fetch.

`ifndef I_ADDR_MISALIGNMENT
`define I_ADDR_MISALIGNMENT 2'd0
`endif
`ifndef ILLEGAL_IR
`define ILLEGAL_IR 2'd1
`endif
`ifndef ECALL
`define ECALL 2'd2
`endif

module trap_seq_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 3,
    parameter logic [31:0] RESET_PC     = 32'h0001_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_misalign,
    input  logic        req_illegal,
    input  logic        req_ecall,
    input  logic [31:0] req_pc,
    input  logic [31:0] req_tval,
    input  logic        mret_req,
    input  logic [31:0] mret_target,
    input  logic [31:0] trap_vector,
    input  logic        redirect_ready,
    output logic        e_raised,
    output logic [1:0]  e_cause,
    output logic [31:0] e_pc,
    output logic [31:0] e_tval,
    output logic        is_mret,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        busy
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RAISE,
        ST_MRET,
        ST_FLUSH,
        ST_REDIRECT
    } state_t;

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

    state_t      state_reg;
    logic [3:0]  cnt_reg;
    logic        e_raised_reg;
    logic [1:0]  e_cause_reg;
    logic [31:0] e_pc_reg;
    logic [31:0] e_tval_reg;
    logic        is_mret_reg;
    logic        flush_reg;
    logic        redirect_valid_reg;
    logic [31:0] redirect_pc_reg;
    logic        busy_reg;

    // Fixed-priority exception arbitration; MRET only considered when no exception is pending.
    logic        exc_any;
    logic [1:0]  exc_cause_next;

    always_comb begin
        exc_any        = req_misalign | req_illegal | req_ecall;
        exc_cause_next = `ECALL;
        if (req_misalign) begin
            exc_cause_next = `I_ADDR_MISALIGNMENT;
        end else if (req_illegal) begin
            exc_cause_next = `ILLEGAL_IR;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg          <= ST_IDLE;
            cnt_reg            <= 4'd0;
            e_raised_reg       <= 1'b0;
            e_cause_reg        <= 2'd0;
            e_pc_reg           <= 32'd0;
            e_tval_reg         <= 32'd0;
            is_mret_reg        <= 1'b0;
            flush_reg          <= 1'b0;
            redirect_valid_reg <= 1'b0;
            redirect_pc_reg    <= RESET_PC;
            busy_reg           <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (exc_any) begin
                        state_reg    <= ST_RAISE;
                        e_raised_reg <= 1'b1;
                        e_cause_reg  <= exc_cause_next;
                        e_pc_reg     <= req_pc;
                        e_tval_reg   <= req_tval;
                        flush_reg    <= 1'b1;
                        busy_reg     <= 1'b1;
                    end else if (mret_req) begin
                        state_reg   <= ST_MRET;
                        is_mret_reg <= 1'b1;
                        flush_reg   <= 1'b1;
                        busy_reg    <= 1'b1;
                    end
                end
                ST_RAISE: begin
                    e_raised_reg    <= 1'b0;
                    redirect_pc_reg <= trap_vector;
                    cnt_reg         <= FLUSH_LOAD;
                    state_reg       <= ST_FLUSH;
                end
                ST_MRET: begin
                    // mepc is captured before the CSR file sees the MRET pulse land.
                    is_mret_reg     <= 1'b0;
                    redirect_pc_reg <= mret_target;
                    cnt_reg         <= FLUSH_LOAD;
                    state_reg       <= ST_FLUSH;
                end
                ST_FLUSH: begin
                    cnt_reg <= cnt_reg - 4'd1;
                    if (cnt_reg == 4'd1) begin
                        state_reg          <= ST_REDIRECT;
                        flush_reg          <= 1'b0;
                        redirect_valid_reg <= 1'b1;
                    end
                end
                ST_REDIRECT: begin
                    if (redirect_ready) begin
                        state_reg          <= ST_IDLE;
                        redirect_valid_reg <= 1'b0;
                        busy_reg           <= 1'b0;
                    end
                end
                default: begin
                    state_reg          <= ST_IDLE;
                    e_raised_reg       <= 1'b0;
                    is_mret_reg        <= 1'b0;
                    flush_reg          <= 1'b0;
                    redirect_valid_reg <= 1'b0;
                    busy_reg           <= 1'b0;
                end
            endcase
        end
    end

    assign e_raised       = e_raised_reg;
    assign e_cause        = e_cause_reg;
    assign e_pc           = e_pc_reg;
    assign e_tval         = e_tval_reg;
    assign is_mret        = is_mret_reg;
    assign flush          = flush_reg;
    assign redirect_valid = redirect_valid_reg;
    assign redirect_pc    = redirect_pc_reg;
    assign busy           = busy_reg;

endmodule

// File: tb/tb_trap_seq_ctrl.sv
// Directed bench for trap_seq_ctrl: a default build (FLUSH_CYCLES=3) and a FLUSH_CYCLES=1 build.

`ifndef I_ADDR_MISALIGNMENT
`define I_ADDR_MISALIGNMENT 2'd0
`endif
`ifndef ILLEGAL_IR
`define ILLEGAL_IR 2'd1
`endif
`ifndef ECALL
`define ECALL 2'd2
`endif

module tb_trap_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rst1 = 1'b1;
    logic        req_misalign = 1'b0;
    logic        req_illegal = 1'b0;
    logic        req_ecall = 1'b0;
    logic [31:0] req_pc = 32'd0;
    logic [31:0] req_tval = 32'd0;
    logic        mret_req = 1'b0;
    logic [31:0] mret_target = 32'd0;
    logic [31:0] trap_vector = 32'd0;
    logic        redirect_ready = 1'b0;

    logic        e_raised, is_mret, flush, redirect_valid, busy;
    logic [1:0]  e_cause;
    logic [31:0] e_pc, e_tval, redirect_pc;

    logic        e_raised1, is_mret1, flush1, redirect_valid1, busy1;
    logic [1:0]  e_cause1;
    logic [31:0] e_pc1, e_tval1, redirect_pc1;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    trap_seq_ctrl dut (
        .clk(clk), .rst(rst),
        .req_misalign(req_misalign), .req_illegal(req_illegal), .req_ecall(req_ecall),
        .req_pc(req_pc), .req_tval(req_tval),
        .mret_req(mret_req), .mret_target(mret_target), .trap_vector(trap_vector),
        .redirect_ready(redirect_ready),
        .e_raised(e_raised), .e_cause(e_cause), .e_pc(e_pc), .e_tval(e_tval),
        .is_mret(is_mret), .flush(flush), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .busy(busy)
    );

    trap_seq_ctrl #(.FLUSH_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst1),
        .req_misalign(req_misalign), .req_illegal(req_illegal), .req_ecall(req_ecall),
        .req_pc(req_pc), .req_tval(req_tval),
        .mret_req(mret_req), .mret_target(mret_target), .trap_vector(trap_vector),
        .redirect_ready(redirect_ready),
        .e_raised(e_raised1), .e_cause(e_cause1), .e_pc(e_pc1), .e_tval(e_tval1),
        .is_mret(is_mret1), .flush(flush1), .redirect_valid(redirect_valid1),
        .redirect_pc(redirect_pc1), .busy(busy1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; inputs are driven and outputs sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int cnt;

    initial begin
        // Reset state
        step();
        step();
        check("rst_e_raised", 32'(e_raised), 32'd0);
        check("rst_is_mret", 32'(is_mret), 32'd0);
        check("rst_flush", 32'(flush), 32'd0);
        check("rst_rvalid", 32'(redirect_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_e_cause", 32'(e_cause), 32'd0);
        check("rst_e_pc", e_pc, 32'd0);
        check("rst_e_tval", e_tval, 32'd0);
        check("rst_rpc", redirect_pc, 32'h0001_0000);
        rst = 1'b0;
        step();

        // Single ECALL, ready tied high (ready early has no effect)
        redirect_ready = 1'b1;
        trap_vector = 32'h0000_0100;
        req_pc = 32'h0001_0040;
        req_tval = 32'h0000_0000;
        req_ecall = 1'b1;
        step(); // N+1
        req_ecall = 1'b0;
        check("ecall_e_raised", 32'(e_raised), 32'd1);
        check("ecall_cause", 32'(e_cause), 32'(`ECALL));
        check("ecall_e_pc", e_pc, 32'h0001_0040);
        check("ecall_flush1", 32'(flush), 32'd1);
        check("ecall_busy1", 32'(busy), 32'd1);
        for (int i = 2; i <= 4; i++) begin
            step();
            check("ecall_flush_n", 32'(flush), 32'd1);
            check("ecall_rv_early", 32'(redirect_valid), 32'd0);
            check("ecall_e_raised_pulse", 32'(e_raised), 32'd0);
        end
        step(); // N+5
        check("ecall_rvalid", 32'(redirect_valid), 32'd1);
        check("ecall_flush_off", 32'(flush), 32'd0);
        check("ecall_rpc", redirect_pc, 32'h0000_0100);
        check("ecall_busy5", 32'(busy), 32'd1);
        step(); // N+6
        check("ecall_busy6", 32'(busy), 32'd0);
        check("ecall_rv6", 32'(redirect_valid), 32'd0);

        // Misalign + illegal + mret together
        req_misalign = 1'b1;
        req_illegal = 1'b1;
        mret_req = 1'b1;
        req_pc = 32'h0001_0042;
        req_tval = 32'h0001_0042;
        mret_target = 32'h0001_0080;
        step();
        req_misalign = 1'b0;
        req_illegal = 1'b0;
        mret_req = 1'b0;
        check("prio_e_raised", 32'(e_raised), 32'd1);
        check("prio_cause", 32'(e_cause), 32'(`I_ADDR_MISALIGNMENT));
        check("prio_tval", e_tval, 32'h0001_0042);
        cnt = 0;
        while (busy && cnt < 20) begin
            check("prio_no_mret", 32'(is_mret), 32'd0);
            step();
            cnt++;
        end
        check("prio_seq_len", 32'(cnt), 32'd5);

        // MRET; target changes after the MRET cycle must not leak through
        mret_req = 1'b1;
        step(); // N+1
        mret_req = 1'b0;
        check("mret_pulse", 32'(is_mret), 32'd1);
        check("mret_e_raised", 32'(e_raised), 32'd0);
        check("mret_flush", 32'(flush), 32'd1);
        step(); // N+2
        mret_target = 32'hDEAD_BEEF;
        check("mret_pulse_off", 32'(is_mret), 32'd0);
        check("mret_e_raised2", 32'(e_raised), 32'd0);
        step();
        step();
        step(); // N+5
        check("mret_rvalid", 32'(redirect_valid), 32'd1);
        check("mret_rpc", redirect_pc, 32'h0001_0080);
        check("mret_no_mret", 32'(is_mret), 32'd0);
        step();
        check("mret_busy_off", 32'(busy), 32'd0);

        // Redirect back-pressure; illegal during the wait is ignored
        redirect_ready = 1'b0;
        trap_vector = 32'h0000_0200;
        req_pc = 32'h0001_00A0;
        req_illegal = 1'b1;
        step(); // N+1
        req_illegal = 1'b0;
        check("bp_cause", 32'(e_cause), 32'(`ILLEGAL_IR));
        step();
        step();
        step();
        step(); // N+5
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            check("bp_rvalid", 32'(redirect_valid), 32'd1);
            check("bp_rpc", redirect_pc, 32'h0000_0200);
            check("bp_busy", 32'(busy), 32'd1);
            if (e_raised) cnt++;
            req_illegal = (i == 2);
            step();
        end
        req_illegal = 1'b0;
        check("bp_no_second_raise", 32'(cnt), 32'd0);
        redirect_ready = 1'b1;
        check("bp_still_valid", 32'(redirect_valid), 32'd1);
        step();
        check("bp_busy_off", 32'(busy), 32'd0);
        check("bp_rv_off", 32'(redirect_valid), 32'd0);

        // Async reset mid-FLUSH
        req_ecall = 1'b1;
        step(); // N+1
        req_ecall = 1'b0;
        step(); // N+2
        rst = 1'b1;
        #1;
        check("rstm_flush", 32'(flush), 32'd0);
        check("rstm_busy", 32'(busy), 32'd0);
        check("rstm_rpc", redirect_pc, 32'h0001_0000);
        #1;
        rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (redirect_valid) cnt++;
        end
        check("rstm_no_rvalid", 32'(cnt), 32'd0);

        // FLUSH_CYCLES=1 build, back-to-back ECALL
        rst1 = 1'b0;
        trap_vector = 32'h0000_0300;
        req_pc = 32'h0001_00C0;
        step();
        req_ecall = 1'b1;
        step(); // N+1
        req_ecall = 1'b0;
        cnt = 0;
        check("fc1_raise", 32'(e_raised1), 32'd1);
        if (flush1) cnt++;
        step(); // N+2
        if (flush1) cnt++;
        step(); // N+3
        if (flush1) cnt++;
        check("fc1_rvalid", 32'(redirect_valid1), 32'd1);
        check("fc1_rpc", redirect_pc1, 32'h0000_0300);
        step(); // N+4
        if (flush1) cnt++;
        check("fc1_flush_cycles", 32'(cnt), 32'd2);
        check("fc1_busy_off", 32'(busy1), 32'd0);
        req_ecall = 1'b1;
        req_pc = 32'h0001_00C4;
        step(); // N+5
        req_ecall = 1'b0;
        check("fc1_b2b_raise", 32'(e_raised1), 32'd1);
        check("fc1_b2b_pc", e_pc1, 32'h0001_00C4);
        step();
        step();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
